// File: rtl/audioplay_pkg.sv
// Shared types and constants for the audioplay display path.
package audioplay_pkg;

    typedef logic [3:0] bcd_t;

    localparam int DEFAULT_SAMPLE_RATE = 48000;

    // Active-low segments, bit0 = a .. bit6 = g.
    localparam logic [6:0] HEX_BLANK = 7'h7F;
    localparam logic [6:0] HEX_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/sevenseg_enc.sv
// BCD digit to active-low seven-segment code; non-decimal codes blank the digit.
module sevenseg_enc
    import audioplay_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] hex
);

    // Table lookup with blank fallback for codes 10..15.
    always_comb begin
        hex = HEX_BLANK;
        if (digit <= 4'd9) begin
            hex = HEX_LUT[digit];
        end
    end

endmodule

// File: rtl/playtime_display.sv
// Elapsed-playback MM:SS timer driven by codec DACLRCK frames.
// Optional build macro PLAYTIME_BLANK_EN: blanks min2 whenever the minutes-tens digit is 0.
module playtime_display
    import audioplay_pkg::*;
#(
    parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       lrck,
    input  logic       run,
    input  logic       clr,
    output logic       sec_tick,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] min1,
    output logic [6:0] min2
);

    localparam int CNT_W = $clog2(SAMPLE_RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_RATE - 1);

`ifdef PLAYTIME_BLANK_EN
    localparam logic [6:0] MIN2_RST = HEX_BLANK;
`else
    localparam logic [6:0] MIN2_RST = HEX_LUT[0];
`endif

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   lrck_prev;
    logic                   frame_pulse;
    logic [CNT_W-1:0]       frame_cnt;
    logic                   sec_wrap;
    bcd_t                   s1, s2, m1, m2;
    logic [6:0]             hex_s1, hex_s2, hex_m1, hex_m2;
    logic [6:0]             min2_next;

    // Reset asserts immediately, releases two clocks after the pin deasserts.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // lrck synchroniser plus registered rising-edge detect.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_sync   <= '0;
            lrck_prev   <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            lrck_sync   <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            lrck_prev   <= lrck_sync[SYNC_STAGES-1];
            frame_pulse <= lrck_sync[SYNC_STAGES-1] & ~lrck_prev;
        end
    end

    assign sec_wrap = run & frame_pulse & (frame_cnt == CNT_LAST);

    // Frame counter and BCD cascade; clr overrides everything in its cycle.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            sec_tick  <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            m1        <= '0;
            m2        <= '0;
        end else if (clr) begin
            frame_cnt <= '0;
            sec_tick  <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            m1        <= '0;
            m2        <= '0;
        end else begin
            sec_tick <= sec_wrap;
            if (run && frame_pulse) begin
                frame_cnt <= sec_wrap ? '0 : frame_cnt + CNT_W'(1);
            end
            if (sec_wrap) begin
                if (s1 == 4'd9) begin
                    s1 <= '0;
                    if (s2 == 4'd5) begin
                        s2 <= '0;
                        if (m1 == 4'd9) begin
                            m1 <= '0;
                            m2 <= (m2 == 4'd9) ? 4'd0 : m2 + 4'd1;
                        end else begin
                            m1 <= m1 + 4'd1;
                        end
                    end else begin
                        s2 <= s2 + 4'd1;
                    end
                end else begin
                    s1 <= s1 + 4'd1;
                end
            end
        end
    end

    sevenseg_enc u_enc_s1 (.digit(s1), .hex(hex_s1));
    sevenseg_enc u_enc_s2 (.digit(s2), .hex(hex_s2));
    sevenseg_enc u_enc_m1 (.digit(m1), .hex(hex_m1));
    sevenseg_enc u_enc_m2 (.digit(m2), .hex(hex_m2));

`ifdef PLAYTIME_BLANK_EN
    assign min2_next = (m2 == 4'd0) ? HEX_BLANK : hex_m2;
`else
    assign min2_next = hex_m2;
`endif

    // Registered HEX outputs, one clock behind the digit registers.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            seg1 <= HEX_LUT[0];
            seg2 <= HEX_LUT[0];
            min1 <= HEX_LUT[0];
            min2 <= MIN2_RST;
        end else begin
            seg1 <= hex_s1;
            seg2 <= hex_s2;
            min1 <= hex_m1;
            min2 <= min2_next;
        end
    end

endmodule

// File: tb/tb_playtime_display.sv
// Directed bench for playtime_display (SAMPLE_RATE=4 main instance, SAMPLE_RATE=2 for the 99:59 wrap).
module tb_playtime_display;

`ifdef PLAYTIME_BLANK_EN
    localparam logic [6:0] MIN2_ZERO = 7'h7F;
`else
    localparam logic [6:0] MIN2_ZERO = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lrck, run, clr;
    logic       sec_tick;
    logic [6:0] seg1, seg2, min1, min2;
    logic       lrck_f, run_f, clr_f;
    logic       sec_tick_f;
    logic [6:0] seg1_f, seg2_f, min1_f, min2_f;

    int n_cmp = 0;
    int n_err = 0;
    int ticks = 0;
    int ticks_f = 0;
    int t0;

    always #5 clk = ~clk;

    playtime_display #(.SAMPLE_RATE(4), .SYNC_STAGES(2)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .lrck(lrck), .run(run), .clr(clr),
        .sec_tick(sec_tick), .seg1(seg1), .seg2(seg2), .min1(min1), .min2(min2)
    );

    playtime_display #(.SAMPLE_RATE(2), .SYNC_STAGES(2)) dut_fast (
        .clk_clk(clk), .reset_reset_n(rst_n), .lrck(lrck_f), .run(run_f), .clr(clr_f),
        .sec_tick(sec_tick_f), .seg1(seg1_f), .seg2(seg2_f), .min1(min1_f), .min2(min2_f)
    );

    always @(negedge clk) begin
        if (sec_tick) ticks++;
        if (sec_tick_f) ticks_f++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            lrck = 1'b1;
            repeat (half) @(negedge clk);
            lrck = 1'b0;
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic frames_f(input int n);
        for (int i = 0; i < n; i++) begin
            lrck_f = 1'b1;
            @(negedge clk);
            lrck_f = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        settle();
    endtask

    initial begin
        rst_n = 1'b0; lrck = 1'b0; run = 1'b1; clr = 1'b0;
        lrck_f = 1'b0; run_f = 1'b1; clr_f = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg1", 32'(seg1), 32'h40);
        chk("rst_seg2", 32'(seg2), 32'h40);
        chk("rst_min1", 32'(min1), 32'h40);
        chk("rst_min2", 32'(min2), 32'(MIN2_ZERO));
        chk("rst_tick", 32'(sec_tick), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-count: 00:01 with frame_cnt=2, then reset discards it.
        frames(6, 10);
        settle();
        chk("pre_rst_seg1", 32'(seg1), 32'h79);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_seg1", 32'(seg1), 32'h40);
        chk("mid_rst_min2", 32'(min2), 32'(MIN2_ZERO));
        chk("mid_rst_tick", 32'(sec_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frames(3, 10);
        settle();
        chk("post_rst_3fr", 32'(seg1), 32'h40);
        frames(1, 10);
        settle();
        chk("post_rst_4fr", 32'(seg1), 32'h79);

        // Cadence and latency of the 4th frame.
        t0 = ticks;
        frames(3, 10);
        lrck = 1'b1;
        repeat (3) @(negedge clk);
        chk("tick_early", 32'(sec_tick), 32'h0);
        @(negedge clk);
        chk("tick_on_time", 32'(sec_tick), 32'h1);
        chk("seg1_before", 32'(seg1), 32'h79);
        @(negedge clk);
        chk("tick_one_cycle", 32'(sec_tick), 32'h0);
        chk("seg1_after", 32'(seg1), 32'h24);
        repeat (5) @(negedge clk);
        lrck = 1'b0;
        repeat (10) @(negedge clk);
        chk("cadence_ticks", 32'(ticks - t0), 32'd1);

        // Pause holds frame_cnt; resume continues from 2.
        pulse_clr();
        chk("clr_seg1", 32'(seg1), 32'h40);
        t0 = ticks;
        frames(2, 10);
        run = 1'b0;
        frames(10, 10);
        settle();
        chk("pause_ticks", 32'(ticks - t0), 32'd0);
        chk("pause_seg1", 32'(seg1), 32'h40);
        run = 1'b1;
        frames(1, 10);
        settle();
        chk("resume_1fr", 32'(ticks - t0), 32'd0);
        frames(1, 10);
        settle();
        chk("resume_2fr", 32'(ticks - t0), 32'd1);
        chk("resume_seg1", 32'(seg1), 32'h79);

        // clr coincident with the wrapping frame_pulse.
        t0 = ticks;
        frames(3, 10);
        lrck = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clrpri_tick", 32'(sec_tick), 32'h0);
        @(negedge clk);
        chk("clrpri_seg1", 32'(seg1), 32'h40);
        chk("clrpri_seg2", 32'(seg2), 32'h40);
        repeat (5) @(negedge clk);
        lrck = 1'b0;
        repeat (10) @(negedge clk);
        chk("clrpri_ticks", 32'(ticks - t0), 32'd0);
        frames(3, 10);
        settle();
        chk("clrpri_cnt0", 32'(ticks - t0), 32'd0);
        frames(1, 10);
        settle();
        chk("clrpri_4fr", 32'(ticks - t0), 32'd1);

        // 00:59 -> 01:00.
        pulse_clr();
        frames(236, 2);
        settle();
        chk("s59_seg2", 32'(seg2), 32'h12);
        chk("s59_seg1", 32'(seg1), 32'h10);
        chk("s59_min1", 32'(min1), 32'h40);
        frames(4, 2);
        settle();
        chk("m1_min1", 32'(min1), 32'h79);
        chk("m1_seg2", 32'(seg2), 32'h40);
        chk("m1_seg1", 32'(seg1), 32'h40);
        chk("m1_min2", 32'(min2), 32'(MIN2_ZERO));

        // Random-phase lrck: 80 frames = 20 s.
        pulse_clr();
        t0 = ticks;
        #($urandom_range(1, 9));
        for (int i = 0; i < 80; i++) begin
            lrck = 1'b1;
            #($urandom_range(25, 120));
            lrck = 1'b0;
            #($urandom_range(25, 120));
        end
        repeat (10) @(negedge clk);
        chk("async_ticks", 32'(ticks - t0), 32'd20);
        chk("async_seg2", 32'(seg2), 32'h24);
        chk("async_seg1", 32'(seg1), 32'h40);
        chk("async_min1", 32'(min1), 32'h40);

        // 99:59 -> 00:00 on the SAMPLE_RATE=2 instance.
        frames_f(11998);
        settle();
        chk("f9959_min2", 32'(min2_f), 32'h10);
        chk("f9959_min1", 32'(min1_f), 32'h10);
        chk("f9959_seg2", 32'(seg2_f), 32'h12);
        chk("f9959_seg1", 32'(seg1_f), 32'h10);
        frames_f(2);
        settle();
        chk("fwrap_ticks", 32'(ticks_f), 32'd6000);
        chk("fwrap_min2", 32'(min2_f), 32'(MIN2_ZERO));
        chk("fwrap_min1", 32'(min1_f), 32'h40);
        chk("fwrap_seg2", 32'(seg2_f), 32'h40);
        chk("fwrap_seg1", 32'(seg1_f), 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
